multi_digit_stopwatch: RTL and testbench

Parametrised stopwatch with N digits, a selectable radix (hex or decimal), a prescaled count tick, start/stop, synchronous clear, lap freeze and a saturate-or-wrap policy at full scale. Each digit drives an active-low seven-segment cathode pattern. The block sits between the board clock/switch inputs and the seven-segment display pins. It is the generalised successor to the fixed 4-digit hex stopwatch.

---
 rtl/stopwatch_pkg.sv | 37 +++
 rtl/seven_segment_encoder.sv | 32 +++
 rtl/multi_digit_stopwatch.sv | 145 ++++++++++++++
 tb/tb_multi_digit_stopwatch.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared segment codes and parameter helpers for the stopwatch
package stopwatch_pkg;

    // Active-low seven-segment patterns, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Only decimal and hexadecimal digits are supported
    function automatic bit radix_legal(input int radix);
        return (radix == 10) || (radix == 16);
    endfunction

    // Clock cycles per count tick
    function automatic int calc_div(input int clock_hz, input int tick_hz);
        return clock_hz / tick_hz;
    endfunction

    // Prescaler width; a divide-by-one still needs a 1-bit register
    function automatic int presc_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// rtl/seven_segment_encoder.sv - combinational 4-bit digit to active-low segment pattern
module seven_segment_encoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Pure lookup; the parent registers the result
    always_comb begin
        segments = SEG_0;
        case (digit)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
        endcase
    end

endmodule

// File: rtl/multi_digit_stopwatch.sv
// rtl/multi_digit_stopwatch.sv - N-digit prescaled stopwatch with lap freeze and segment outputs
module multi_digit_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLOCK_HZ   = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int RADIX      = 16,
    parameter int WRAP       = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    run,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [7*NUM_DIGITS-1:0] seven_segment,
    output logic                    tick,
    output logic                    overflow,
    output logic                    lap_active
);

    localparam int DW      = 4 * NUM_DIGITS;
    localparam int SW      = 7 * NUM_DIGITS;
    localparam int DIV     = calc_div(CLOCK_HZ, TICK_HZ);
    localparam int PRESC_W = presc_width(DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [3:0]         DIGIT_MAX  = 4'(RADIX - 1);

    if (!radix_legal(RADIX)) begin : g_bad_radix
        $error("multi_digit_stopwatch: RADIX must be 10 or 16");
    end
    if (DIV < 1) begin : g_bad_div
        $error("multi_digit_stopwatch: CLOCK_HZ/TICK_HZ must be at least 1");
    end

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DW-1:0]      count_q, count_d;
    logic [DW-1:0]      lap_q, lap_d;
    logic               lap_active_q, lap_active_d;
    logic               overflow_q, overflow_d;
    logic               tick_q, tick_d;
    logic [SW-1:0]      seg_q, seg_d;

    logic               inc;
    logic               carry;
    logic               at_full;
    logic [DW-1:0]      count_inc;
    logic [DW-1:0]      disp_src;

    assign inc = run && (presc_q == PRESC_LAST);

    // Single-edge ripple increment across all digits, plus full-scale detect
    always_comb begin
        carry     = 1'b1;
        at_full   = 1'b1;
        count_inc = count_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            at_full = at_full && (count_q[4*i +: 4] == DIGIT_MAX);
            if (carry) begin
                if (count_q[4*i +: 4] == DIGIT_MAX) begin
                    count_inc[4*i +: 4] = 4'h0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'h1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Next state: clear beats lap, lap captures the pre-tick count, tick advances
    always_comb begin
        presc_d      = presc_q;
        count_d      = count_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        tick_d       = 1'b0;
        if (clear) begin
            presc_d      = '0;
            count_d      = '0;
            lap_d        = '0;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            if (run) begin
                presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            end
            if (lap) begin
                if (lap_active_q) begin
                    lap_active_d = 1'b0;
                end else begin
                    lap_d        = count_q;
                    lap_active_d = 1'b1;
                end
            end
            if (inc) begin
                tick_d = 1'b1;
                if (at_full) begin
                    overflow_d = 1'b1;
                    count_d    = (WRAP != 0) ? count_inc : count_q;
                end else begin
                    count_d = count_inc;
                end
            end
        end
    end

    assign disp_src = lap_active_q ? lap_q : count_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seven_segment_encoder u_enc (
            .digit    (disp_src[4*g +: 4]),
            .segments (seg_d[7*g +: 7])
        );
    end

    // State and display registers; reset display shows all zeros
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            count_q      <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            tick_q       <= 1'b0;
            seg_q        <= {NUM_DIGITS{SEG_0}};
        end else begin
            presc_q      <= presc_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            tick_q       <= tick_d;
            seg_q        <= seg_d;
        end
    end

    assign digits_out    = count_q;
    assign seven_segment = seg_q;
    assign tick          = tick_q;
    assign overflow      = overflow_q;
    assign lap_active    = lap_active_q;

endmodule

// File: tb/tb_multi_digit_stopwatch.sv
// tb/tb_multi_digit_stopwatch.sv - self-checking bench for multi_digit_stopwatch
module tb_multi_digit_stopwatch;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic run   = 1'b0;
    logic lap   = 1'b0;

    always #5 clock = ~clock;

    logic [15:0] dig_a, dig_b;
    logic [7:0]  dig_c, dig_d;
    logic [27:0] seg_a, seg_b;
    logic [13:0] seg_c, seg_d;
    logic        tick_a, tick_b, tick_c, tick_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic        la_a, la_b, la_c, la_d;

    multi_digit_stopwatch #(.NUM_DIGITS(4), .CLOCK_HZ(10), .TICK_HZ(1), .RADIX(16), .WRAP(0)) u_a (
        .clock(clock), .reset(reset), .clear(clear), .run(run), .lap(lap),
        .digits_out(dig_a), .seven_segment(seg_a), .tick(tick_a), .overflow(ovf_a), .lap_active(la_a));
    multi_digit_stopwatch #(.NUM_DIGITS(4), .CLOCK_HZ(10), .TICK_HZ(1), .RADIX(10), .WRAP(0)) u_b (
        .clock(clock), .reset(reset), .clear(clear), .run(run), .lap(lap),
        .digits_out(dig_b), .seven_segment(seg_b), .tick(tick_b), .overflow(ovf_b), .lap_active(la_b));
    multi_digit_stopwatch #(.NUM_DIGITS(2), .CLOCK_HZ(10), .TICK_HZ(1), .RADIX(16), .WRAP(0)) u_c (
        .clock(clock), .reset(reset), .clear(clear), .run(run), .lap(lap),
        .digits_out(dig_c), .seven_segment(seg_c), .tick(tick_c), .overflow(ovf_c), .lap_active(la_c));
    multi_digit_stopwatch #(.NUM_DIGITS(2), .CLOCK_HZ(10), .TICK_HZ(1), .RADIX(16), .WRAP(1)) u_d (
        .clock(clock), .reset(reset), .clear(clear), .run(run), .lap(lap),
        .digits_out(dig_d), .seven_segment(seg_d), .tick(tick_d), .overflow(ovf_d), .lap_active(la_d));

    logic [31:0] act_dig [4];
    logic [31:0] act_seg [4];
    logic        act_tick [4];
    logic        act_ovf [4];
    logic        act_la [4];

    assign act_dig[0] = {16'b0, dig_a};
    assign act_dig[1] = {16'b0, dig_b};
    assign act_dig[2] = {24'b0, dig_c};
    assign act_dig[3] = {24'b0, dig_d};
    assign act_seg[0] = {4'b0, seg_a};
    assign act_seg[1] = {4'b0, seg_b};
    assign act_seg[2] = {18'b0, seg_c};
    assign act_seg[3] = {18'b0, seg_d};
    assign act_tick[0] = tick_a;
    assign act_tick[1] = tick_b;
    assign act_tick[2] = tick_c;
    assign act_tick[3] = tick_d;
    assign act_ovf[0] = ovf_a;
    assign act_ovf[1] = ovf_b;
    assign act_ovf[2] = ovf_c;
    assign act_ovf[3] = ovf_d;
    assign act_la[0] = la_a;
    assign act_la[1] = la_b;
    assign act_la[2] = la_c;
    assign act_la[3] = la_d;

    // Instance configuration as seen by the model
    int radix_of [4] = '{16, 10, 16, 16};
    int ndig_of  [4] = '{4, 4, 2, 2};
    int wrap_of  [4] = '{0, 0, 0, 1};

    // Model state: counts held as plain integers
    int          m_cnt  [4];
    int          m_lapv [4];
    bit          m_la   [4];
    bit          m_ovf  [4];
    bit          m_tick [4];
    logic [31:0] m_seg  [4];
    int          m_presc;
    bit          m_inc;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic int full_scale(input int k);
        int v;
        v = 1;
        for (int i = 0; i < ndig_of[k]; i++) v = v * radix_of[k];
        return v - 1;
    endfunction

    function automatic logic [31:0] pack_digits(input int v, input int k);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < ndig_of[k]; i++) begin
            r[4*i +: 4] = 4'(x % radix_of[k]);
            x = x / radix_of[k];
        end
        return r;
    endfunction

    function automatic logic [31:0] pack_segs(input int v, input int k);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < ndig_of[k]; i++) begin
            r[7*i +: 7] = enc(x % radix_of[k]);
            x = x / radix_of[k];
        end
        return r;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endtask

    // Behavioural model of every instance
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_presc = 0;
            for (int k = 0; k < 4; k++) begin
                m_cnt[k]  = 0;
                m_lapv[k] = 0;
                m_la[k]   = 1'b0;
                m_ovf[k]  = 1'b0;
                m_tick[k] = 1'b0;
                m_seg[k]  = pack_segs(0, k);
            end
        end else begin
            m_inc = run && (m_presc == 9);
            for (int k = 0; k < 4; k++) begin
                m_seg[k] = pack_segs(m_la[k] ? m_lapv[k] : m_cnt[k], k);
                if (clear) begin
                    m_cnt[k]  = 0;
                    m_lapv[k] = 0;
                    m_la[k]   = 1'b0;
                    m_ovf[k]  = 1'b0;
                    m_tick[k] = 1'b0;
                end else begin
                    if (lap) begin
                        if (m_la[k]) m_la[k] = 1'b0;
                        else begin
                            m_lapv[k] = m_cnt[k];
                            m_la[k]   = 1'b1;
                        end
                    end
                    m_tick[k] = m_inc;
                    if (m_inc) begin
                        if (m_cnt[k] == full_scale(k)) begin
                            m_ovf[k] = 1'b1;
                            if (wrap_of[k] != 0) m_cnt[k] = 0;
                        end else begin
                            m_cnt[k] = m_cnt[k] + 1;
                        end
                    end
                end
            end
            if (clear) m_presc = 0;
            else if (run) m_presc = (m_presc == 9) ? 0 : m_presc + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                check("digits", k, act_dig[k], pack_digits(m_cnt[k], k));
                check("segments", k, act_seg[k], m_seg[k]);
                check("tick", k, {31'b0, act_tick[k]}, {31'b0, m_tick[k]});
                check("overflow", k, {31'b0, act_ovf[k]}, {31'b0, m_ovf[k]});
                check("lap_active", k, {31'b0, act_la[k]}, {31'b0, m_la[k]});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clock);
        lap = 1'b0;
    endtask

    initial begin
        cycles(2);
        reset = 1'b0;
        check("lit_rst_dig", 0, {16'b0, dig_a}, 32'h0);
        check("lit_rst_seg", 0, {4'b0, seg_a}, {4'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        check("lit_rst_flags", 0, {29'b0, tick_a, ovf_a, la_a}, 32'h0);

        // First tick lands DIV cycles after run rises
        run = 1'b1;
        cycles(9);
        check("lit_t1_no_tick", 0, {31'b0, tick_a}, 32'h0);
        cycles(1);
        check("lit_t1_tick", 0, {31'b0, tick_a}, 32'h1);
        check("lit_t1_dig", 0, {16'b0, dig_a}, 32'h0001);
        cycles(1);
        check("lit_t1_seg", 0, {4'b0, seg_a}, {4'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001});

        // Decimal and hex carry into the second digit
        pulse_clear();
        cycles(100);
        check("lit_dec10", 1, {16'b0, dig_b}, 32'h0010);
        check("lit_hex10", 0, {16'b0, dig_a}, 32'h000A);
        cycles(60);
        check("lit_hex16", 0, {16'b0, dig_a}, 32'h0010);

        // Full scale: saturate versus wrap, then clear overflow
        pulse_clear();
        cycles(2550);
        check("lit_sat_255", 2, {24'b0, dig_c}, 32'hFF);
        check("lit_sat_ovf0", 2, {31'b0, ovf_c}, 32'h0);
        cycles(10);
        check("lit_sat_256", 2, {24'b0, dig_c}, 32'hFF);
        check("lit_sat_ovf1", 2, {31'b0, ovf_c}, 32'h1);
        check("lit_wrap_256", 3, {24'b0, dig_d}, 32'h00);
        check("lit_wrap_ovf1", 3, {31'b0, ovf_d}, 32'h1);
        cycles(20);
        check("lit_sat_hold", 2, {24'b0, dig_c}, 32'hFF);
        pulse_clear();
        check("lit_clr_ovf", 2, {31'b0, ovf_c}, 32'h0);

        // Hold at prescaler 5, resume
        cycles(5);
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("lit_hold_tick", 0, {31'b0, tick_a}, 32'h0);
        end
        run = 1'b1;
        cycles(4);
        check("lit_resume_early", 0, {31'b0, tick_a}, 32'h0);
        cycles(1);
        check("lit_resume_tick", 0, {31'b0, tick_a}, 32'h1);
        check("lit_resume_dig", 0, {16'b0, dig_a}, 32'h0001);

        // Lap freeze at 3 while the live count reaches 7
        pulse_clear();
        cycles(30);
        pulse_lap();
        check("lit_lap_on", 0, {31'b0, la_a}, 32'h1);
        cycles(40);
        check("lit_lap_live", 0, {16'b0, dig_a}, 32'h0007);
        check("lit_lap_seg3", 0, {25'b0, seg_a[6:0]}, {25'b0, 7'b0110000});
        pulse_lap();
        check("lit_lap_off", 0, {31'b0, la_a}, 32'h0);
        check("lit_lap_lag", 0, {25'b0, seg_a[6:0]}, {25'b0, 7'b0110000});
        cycles(1);
        check("lit_lap_seg7", 0, {25'b0, seg_a[6:0]}, {25'b0, 7'b1111000});

        // Asynchronous reset between edges at count 5
        pulse_clear();
        cycles(50);
        check("lit_pre_rst", 0, {16'b0, dig_a}, 32'h0005);
        #2;
        reset = 1'b1;
        #1;
        check("lit_async_dig", 0, {16'b0, dig_a}, 32'h0);
        check("lit_async_ovf", 0, {31'b0, ovf_a}, 32'h0);
        check("lit_async_seg", 0, {4'b0, seg_a}, {4'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        @(negedge clock);
        reset = 1'b0;

        // Lap and clear in the same cycle
        cycles(25);
        pulse_lap();
        check("lit_lapclr_pre", 0, {31'b0, la_a}, 32'h1);
        lap   = 1'b1;
        clear = 1'b1;
        @(negedge clock);
        lap   = 1'b0;
        clear = 1'b0;
        check("lit_lapclr_la", 0, {31'b0, la_a}, 32'h0);
        check("lit_lapclr_dig", 0, {16'b0, dig_a}, 32'h0);
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
